stage_ram_arbiter: RTL
======================

# stage_ram_arbiter

Time-multiplexes the single-port stage RAM between the VGA display fetch and game-logic read/write requests. The display fetch owns every other system-clock cycle during active video, so it is never stalled. Game logic owns the remaining cycles, and all cycles during blanking. The block sits between `vga_controller`/`color_mapper` and `stage_ram`, replacing the direct `DrawY*640+DrawX` address hookup.

## Interface
Parameters:
- `H_RES`, 640, visible pixels per line
- `V_RES`, 480, visible lines
- `ADDR_W`, 19, RAM address width (H_RES*V_RES = 307200 < 2^19)
- `DATA_W`, 2, stage colour-index width
- `FIFO_DEPTH`, 4, request queue depth (power of two)

Ports:
- `Clk`  in  1  50 MHz system clock; the only clock
- `Reset`  in  1  synchronous, active-high
- `DrawX`  in  10  current pixel column from `vga_controller`
- `DrawY`  in  10  current pixel row from `vga_controller`
- `vid_on`  in  1  high during active video
- `req_valid`  in  1  game-logic request present
- `req_ready`  out  1  queue can accept a request
- `req_we`  in  1  1 = write, 0 = read
- `req_addr`  in  ADDR_W  request address
- `req_wdata`  in  DATA_W  write data
- `rsp_valid`  out  1  one-cycle read-data strobe
- `rsp_rdata`  out  DATA_W  read data
- `oob_flag`  out  1  sticky flag: an out-of-range request was seen
- `ram_addr`  out  ADDR_W  to `stage_ram.address`
- `ram_data`  out  DATA_W  to `stage_ram.data`
- `ram_wren`  out  1  to `stage_ram.wren`
- `ram_q`  in  DATA_W  from `stage_ram.q`; valid 1 cycle after the address is presented
- `pixel_index`  out  DATA_W  stage colour index to `color_mapper`

## Operation
- **Phase bit** `ph`: reset to 0, toggles every cycle. `ph=0` is the display slot and `ph=1` is the request slot. `vga_controller` resets on the same `Reset`, so `ph=0` aligns with the first half of each pixel-clock period.
- **Display slot** (`ph=0` and `disp_act`):
  - `disp_act` = `vid_on` AND `DrawX<H_RES` AND `DrawY<V_RES`.
  - Drive `ram_addr = DrawY*H_RES + DrawX`, computed at ADDR_W bits, and `ram_wren=0`.
- **Request slot**: any cycle that is not a display slot. During blanking this is every cycle; during active video it is every `ph=1` cycle.
  - If the queue is non-empty, pop the head and issue it to the RAM.
- **Request queue**: FIFO of {we, addr, wdata}, FIFO_DEPTH entries.
  - `req_ready` = NOT full.
  - A push happens on `req_valid && req_ready`.
  - Push and pop in the same cycle are allowed, and occupancy is unchanged.
  - Requests execute strictly in order, so a read after a write to the same address returns the new data.
- **Issue rules**:
  - Write: `ram_wren=1` for exactly the issue cycle, with `ram_addr`/`ram_data` from the head entry.
  - Read: `ram_wren=0`. `ram_q` is captured the next cycle. `rsp_valid=1` with `rsp_rdata` on the cycle after capture, for 1 cycle.
  - Out-of-range address (`addr >= H_RES*V_RES`): the entry is popped and no RAM access occurs (`ram_wren=0`). A read still produces `rsp_valid` with `rsp_rdata=0`. `oob_flag` sets and stays set until `Reset`.
- **Idle cycle**: a request slot with an empty queue drives `ram_wren=0` and `ram_addr=0`.
- **Display data**: `ram_q` for a display-slot issue is registered into `pixel_index` two cycles after issue. `pixel_index` holds its value until the next display capture. It is forced to 0 in any display-slot capture cycle whose originating slot had `disp_act=0`.

## Timing
- **Reset values**: `ph=0`, queue empty, `req_ready=1`, `rsp_valid=0`, `rsp_rdata=0`, `oob_flag=0`, `ram_wren=0`, `ram_addr=0`, `ram_data=0`, `pixel_index=0`.
- **Reset mid-operation**: queued and in-flight reads are discarded, and no `rsp_valid` is issued for them.
- **Display latency**: issue at cycle t (`ph=0`), `pixel_index` valid at t+2. The displayed pixel therefore lags `DrawX` by one pixel clock; `color_mapper` compensates.
- **Request latency**:
  - Accept to issue: at least 1 cycle.
  - Read issue to `rsp_valid`: exactly 2 cycles.
  - Worst-case issue wait during active video with an empty queue: 2 cycles.
- **Throughput**: 1 request per 2 cycles in active video; 1 per cycle in blanking.
- **RAM port**: `ram_wren` is never high in a display slot.
- **Boundary transitions**: a `vid_on` edge takes effect at the next slot decision, with no lost or duplicated request.

## Test plan
1. Assert `Reset` for 2 cycles → every output matches the reset values above, `req_ready=1`, `ram_wren=0`.
2. `vid_on=1`, `DrawX=3`, `DrawY=2`, RAM[1283]=2, queue empty → on `ph=0`, `ram_addr=1283` with `ram_wren=0`; two cycles later `pixel_index=2`.
3. `vid_on=1`, push a write (addr 100, data 3) → `ram_wren=1` only on a `ph=1` cycle, with `ram_addr=100`, `ram_data=3`; display addresses continue uninterrupted on `ph=0`.
4. `vid_on=0`, push 5 writes back-to-back → `req_ready` drops after the 4th accept (or stays high if a pop coincides); all writes issue on consecutive cycles in order.
5. Write (addr 500, data 1), then read addr 500 → `rsp_valid` pulses once with `rsp_rdata=1`, exactly 2 cycles after the read's issue cycle.
6. Write to addr 307200, then read addr 307200 → no `ram_wren` pulse; `rsp_rdata=0` with `rsp_valid=1`; `oob_flag=1` and it holds until `Reset`.

Source files
------------

// File: rtl/stage_ram_arbiter.sv
// stage_ram_arbiter
// Shares the single-port stage RAM between the VGA display fetch and
// game-logic read/write requests. The even phase of every pixel period is
// reserved for the display during active video; every other cycle serves
// the request queue in strict arrival order.
//
// Ports
//   Clk, Reset              system clock, synchronous active-high reset
//   DrawX, DrawY, vid_on    raster position / active-video from vga_controller
//   req_valid/ready/we/addr/wdata   game-logic request channel
//   rsp_valid, rsp_rdata    one-cycle read-data strobe
//   oob_flag                sticky: an out-of-range request was accepted
//   ram_addr/data/wren/q    stage_ram port (q valid one cycle after address)
//   pixel_index             colour index to color_mapper
`timescale 1ns/1ps
module stage_ram_arbiter #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              vid_on,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              oob_flag,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] pixel_index
);

  localparam int                PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]    CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] NPIX     = ADDR_W'(H_RES * V_RES);
  localparam logic [ADDR_W-1:0] H_RES_A  = ADDR_W'(H_RES);
  localparam logic [9:0]        H_LIM    = 10'(H_RES);
  localparam logic [9:0]        V_LIM    = 10'(V_RES);

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
    return ADDR_W'(y) * H_RES_A + ADDR_W'(x);
  endfunction

  // Request queue storage (data only, never reset)
  logic              fifo_we_q    [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_q  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_wdata_q [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic              ph_q;
  logic              oob_q;

  logic              rd_vld_p1_q, rd_oob_p1_q;
  logic              pix_cap_p1_q, pix_act_p1_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [DATA_W-1:0] pixel_q;

  logic              disp_act, disp_slot;
  logic              empty, full, push, pop;
  logic              head_we, head_oob;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;
  logic              issue_rd;

  // Stage p0: slot decision and RAM issue
  always_comb begin
    disp_act   = vid_on && (DrawX < H_LIM) && (DrawY < V_LIM);
    disp_slot  = !ph_q && disp_act;
    empty      = (cnt_q == '0);
    full       = (cnt_q == CNT_FULL);
    push       = req_valid && !full;
    pop        = !disp_slot && !empty;
    head_we    = fifo_we_q[rd_ptr_q];
    head_addr  = fifo_addr_q[rd_ptr_q];
    head_wdata = fifo_wdata_q[rd_ptr_q];
    head_oob   = (head_addr >= NPIX);
    // Out-of-range reads still owe a response, just with no RAM access.
    issue_rd   = pop && !head_we;

    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + (PTR_W+1)'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - (PTR_W+1)'(1);
    end

    ram_addr = '0;
    ram_data = '0;
    ram_wren = 1'b0;
    if (disp_slot) begin
      ram_addr = pix_addr(DrawX, DrawY);
    end else if (pop && !head_oob) begin
      ram_addr = head_addr;
      ram_wren = head_we;
      ram_data = head_we ? head_wdata : '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_we_q[wr_ptr_q]    <= req_we;
      fifo_addr_q[wr_ptr_q]  <= req_addr;
      fifo_wdata_q[wr_ptr_q] <= req_wdata;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ph_q         <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      oob_q        <= 1'b0;
      rd_vld_p1_q  <= 1'b0;
      rd_oob_p1_q  <= 1'b0;
      pix_cap_p1_q <= 1'b0;
      pix_act_p1_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      pixel_q      <= '0;
    end else begin
      ph_q  <= ~ph_q;
      cnt_q <= cnt_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push && (req_addr >= NPIX)) begin
        oob_q <= 1'b1;
      end

      // Stage p1: RAM output becomes valid; remember what was issued
      rd_vld_p1_q  <= issue_rd;
      rd_oob_p1_q  <= head_oob;
      pix_cap_p1_q <= !ph_q;
      pix_act_p1_q <= disp_act;

      // Stage p2: capture RAM output into response / pixel registers
      rsp_valid_q <= rd_vld_p1_q;
      if (rd_vld_p1_q) begin
        rsp_rdata_q <= rd_oob_p1_q ? '0 : ram_q;
      end
      // Even-phase slots that were not display fetches blank the pixel.
      if (pix_cap_p1_q) begin
        pixel_q <= pix_act_p1_q ? ram_q : '0;
      end
    end
  end

  assign req_ready   = !full;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign oob_flag    = oob_q;
  assign pixel_index = pixel_q;

endmodule
